// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: 8N1 frames with optional even parity and one or two stop bits.
// Accepts a one-cycle send pulse in IDLE; busy and the start bit appear on the very next cycle.
module uart_tx_serializer #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] transmit_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baud_last_c;
    logic               stop_last_c;

    assign baud_last_c = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_last_c = (bit_idx_q == 3'(STOP_BITS - 1));

    // State and registered outputs; reset wins over any pending send.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state; tx/busy/tx_done are computed for the coming cycle so they stay registered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    state_d   = S_START;
                    shift_d   = transmit_data;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_last_c) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = ^shift_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_last_c) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                end
            end
            S_STOP: begin
                baud_d = baud_q + CNT_W'(1);
                // Raise tx_done one cycle early so the registered pulse lands in the final stop cycle.
                done_d = stop_last_c && (baud_q == CNT_W'(CLKS_PER_BIT - 2));
                if (baud_last_c) begin
                    baud_d = '0;
                    if (stop_last_c) begin
                        state_d   = S_IDLE;
                        bit_idx_d = '0;
                        busy_d    = 1'b0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule
